// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard scan-code receiver with a small key FIFO.
// Frames are sampled on synchronized ps2_clk falling edges. E0/F0 prefix
// bytes become ext/brk flags that are folded into the next pushed code.
// Optional feature: define PS2_PARITY_CHK_EN to enforce odd parity and
// report failures on the sticky parity_err output.
module ps2_scan_rx #(
    parameter int FIFO_AW     = 2,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd,
    output logic [9:0] data_out,
    output logic       ready,
    output logic       overflow,
    output logic       parity_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK} state_t;

    // Two-flop synchronizers; index 0 is ps2_clk, index 1 is ps2_data.
    logic [1:0] line_raw;
    logic [1:0] line_sync;
    logic [1:0] line_prev;
    assign line_raw = {ps2_data, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;
            // Idle-high lines reset to 1 so reset release creates no edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                    prev_reg <= 1'b1;
                end else begin
                    meta_reg <= line_raw[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                end
            end
            assign line_sync[gi] = sync_reg;
            assign line_prev[gi] = prev_reg;
        end
    endgenerate

    logic fall;
    logic data_bit;
    assign fall     = line_prev[0] & ~line_sync[0];
    assign data_bit = line_sync[1];

    state_t            state_reg, state_next;
    logic [3:0]        bit_cnt_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic [8:0]        shift_reg;
    logic              stop_reg;
    logic              ext_reg, brk_reg, perr_reg;
    logic              timeout;

    assign timeout = !fall && (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state: start bit opens a frame, stop bit or silence closes it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (fall && !data_bit) state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (fall && bit_cnt_reg == 4'd9) state_next = ST_CHECK;
                else if (timeout)                state_next = ST_IDLE;
            end
            ST_CHECK: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Frame decode outputs, only meaningful during the single CHECK cycle.
    logic frame_ok, parity_fail, push, set_ext, set_brk, abandon;
    logic frame_done;
    logic [9:0] entry;
`ifdef PS2_PARITY_CHK_EN
    logic parity_ok;
    assign parity_ok = ^shift_reg;
`else
    logic parity_unused;
    assign parity_unused = shift_reg[8];
`endif
    always_comb begin
        frame_done  = (state_reg == ST_CHECK);
`ifdef PS2_PARITY_CHK_EN
        frame_ok    = stop_reg & parity_ok;
        parity_fail = frame_done & ~parity_ok;
`else
        frame_ok    = stop_reg;
        parity_fail = 1'b0;
`endif
        set_ext = frame_done & frame_ok & (shift_reg[7:0] == 8'hE0);
        set_brk = frame_done & frame_ok & (shift_reg[7:0] == 8'hF0);
        push    = frame_done & frame_ok & ~set_ext & ~set_brk;
        abandon = (state_reg == ST_SHIFT) & timeout;
        entry   = {ext_reg, brk_reg, shift_reg[7:0]};
    end

    // Bit shifting, silence counting and prefix flag tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg <= 4'd0;
            to_cnt_reg  <= '0;
            shift_reg   <= 9'd0;
            stop_reg    <= 1'b0;
            ext_reg     <= 1'b0;
            brk_reg     <= 1'b0;
            perr_reg    <= 1'b0;
        end else begin
            if (state_reg == ST_SHIFT) begin
                if (fall) begin
                    to_cnt_reg <= '0;
                    if (bit_cnt_reg == 4'd9) begin
                        stop_reg <= data_bit;
                    end else begin
                        shift_reg   <= {data_bit, shift_reg[8:1]};
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    end
                end else begin
                    to_cnt_reg <= to_cnt_reg + TO_W'(1);
                end
            end else begin
                bit_cnt_reg <= 4'd0;
                to_cnt_reg  <= '0;
            end
            if (abandon || push) begin
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end else begin
                if (set_ext) ext_reg <= 1'b1;
                if (set_brk) brk_reg <= 1'b1;
            end
            if (parity_fail) perr_reg <= 1'b1;
        end
    end

    // Key FIFO.
    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               ovf_reg;
    logic               empty, full, do_rd, do_wr;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (FIFO_AW + 1)'(DEPTH));
    assign do_rd = rd & ~empty;
    assign do_wr = push & (~full | do_rd);

    // Storage write; contents need no reset because empty masks data_out.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg] <= entry;
    end

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + (FIFO_AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (FIFO_AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (push && full && !do_rd) ovf_reg <= 1'b1;
        end
    end

    assign ready      = ~empty;
    assign data_out   = empty ? 10'd0 : mem[rd_ptr_reg];
    assign overflow   = ovf_reg;
    assign parity_err = perr_reg;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench for ps2_scan_rx: a spec-level key model pushes expected
// FIFO entries when a frame is issued; a monitor pops whenever ready is seen.
module tb_ps2_scan_rx;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int TO    = 300;
    localparam int H     = 20;   // clk cycles per PS/2 clock half period
`ifdef PS2_PARITY_CHK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       stim_rd = 1'b0;
    logic       mon_rd = 1'b0;
    logic       rd;
    logic [9:0] data_out;
    logic       ready, overflow, parity_err;

    assign rd = stim_rd | mon_rd;

    always #5 clk = ~clk;

    ps2_scan_rx #(.FIFO_AW(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd(rd), .data_out(data_out), .ready(ready),
        .overflow(overflow), .parity_err(parity_err)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [9:0] exp_q[$];
    bit         m_ext, m_brk, m_ovf, m_perr;
    bit         auto_rd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare one entry each time the DUT shows ready.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_rd) begin
                mon_rd = 1'b0;
            end else if (auto_rd && ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got 0x%0h expected no entry", data_out);
                end else begin
                    $display("[TB] pop 0x%03h", data_out);
                    check("sb_entry", {22'd0, data_out}, {22'd0, exp_q[0]});
                    exp_q.delete(0);
                end
                mon_rd = 1'b1;
            end
        end
    end

    // mode 0: plain, 1: measure stop-to-ready latency, 2: rd on the push cycle
    task automatic send_frame(input logic [7:0] b, input bit good_par,
                              input int nbits, input int mode);
        logic [10:0] bits;
        int lat;
        bits = {1'b1, good_par ? ~^b : ^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            cyc(H);
            ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                lat = 0;
                while (!ready && lat < 10) begin
                    cyc(1);
                    lat++;
                end
                check("latency_le5", {31'd0, (lat <= 5) && ready}, 32'd1);
                cyc(H);
            end else if (i == 10 && mode == 2) begin
                cyc(3);
                stim_rd = 1'b1;
                cyc(1);
                stim_rd = 1'b0;
                cyc(H - 4);
            end else begin
                cyc(H);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // Spec-level model of one received byte, then the frame itself.
    task automatic key(input logic [7:0] b, input bit good_par, input int mode);
        logic [9:0] e;
        bit valid;
        valid = 1'b1;
        if (PAR_EN && !good_par) begin
            valid  = 1'b0;
            m_perr = 1'b1;
        end
        if (valid) begin
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                e = {m_ext, m_brk, b};
                m_ext = 1'b0;
                m_brk = 1'b0;
                if (mode == 2) begin
                    check("simul_head", {22'd0, data_out}, {22'd0, exp_q[0]});
                    exp_q.delete(0);
                    exp_q.push_back(e);
                end else if (!auto_rd && exp_q.size() >= DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    exp_q.push_back(e);
                end
            end
        end
        $display("[TB] key 0x%02h par_ok=%0d mode=%0d", b, good_par, mode);
        send_frame(b, good_par, 11, mode);
        cyc(2 * H + $urandom_range(0, 10));
    endtask

    function automatic logic [7:0] rc();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'hE0 || b == 8'hF0);
        return b;
    endfunction

    task automatic drain();
        int t;
        auto_rd = 1'b1;
        t = 0;
        while ((ready || exp_q.size() != 0) && t < 200) begin
            cyc(1);
            t++;
        end
        cyc(3);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_ready", {31'd0, ready}, 32'd0);
        check("drain_data", {22'd0, data_out}, 32'd0);
    endtask

    task automatic status(input string tag);
        $display("[TB] status %s ovf=%0d perr=%0d", tag, overflow, parity_err);
        check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, m_ovf});
        check({tag, "_parity_err"}, {31'd0, parity_err}, {31'd0, m_perr});
    endtask

    initial begin
        logic [7:0] b;
        bit good;
        rst = 1'b1;
        cyc(5);
        check("rst_data", {22'd0, data_out}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_perr", {31'd0, parity_err}, 32'd0);
        rst = 1'b0;
        cyc(5);

        // First key: latency and pop behaviour observed directly.
        send_frame(8'h1C, 1'b1, 11, 1);
        check("first_data", {22'd0, data_out}, 32'h01C);
        stim_rd = 1'b1;
        cyc(1);
        stim_rd = 1'b0;
        check("pop_ready", {31'd0, ready}, 32'd0);
        check("pop_data", {22'd0, data_out}, 32'd0);
        cyc(2 * H);

        // Prefix handling, parity, random traffic, timeout recovery.
        auto_rd = 1'b1;
        key(8'hF0, 1'b1, 0);
        key(8'h1C, 1'b1, 0);
        key(8'hE0, 1'b1, 0);
        key(8'hF0, 1'b1, 0);
        key(8'h75, 1'b1, 0);
        key(8'h1C, 1'b0, 0);
        status("parity");
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 5) == 0) b = $urandom_range(0, 1) ? 8'hE0 : 8'hF0;
            else b = 8'($urandom);
            good = ($urandom_range(0, 7) != 0);
            key(b, good, 0);
        end
        key(8'hE0, 1'b1, 0);
        $display("[TB] partial frame then silence");
        send_frame(8'h55, 1'b1, 4, 0);
        cyc(2 * TO + H);
        m_ext = 1'b0;
        m_brk = 1'b0;
        key(8'h29, 1'b1, 0);
        drain();
        status("random");

        // Fill, simultaneous rd+push while full, then overflow.
        auto_rd = 1'b0;
        cyc(5);
        for (int i = 0; i < DEPTH; i++) key(rc(), 1'b1, 0);
        check("full_ready", {31'd0, ready}, 32'd1);
        key(rc(), 1'b1, 2);
        status("simul");
        key(rc(), 1'b1, 0);
        status("ovf");
        drain();

        // Reset in the middle of a frame that follows an E0 prefix.
        auto_rd = 1'b0;
        cyc(5);
        key(rc(), 1'b1, 0);
        key(rc(), 1'b1, 0);
        key(8'hE0, 1'b1, 0);
        send_frame(8'h33, 1'b1, 5, 0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
        m_perr = 1'b0;
        check("midrst_data", {22'd0, data_out}, 32'd0);
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_ovf", {31'd0, overflow}, 32'd0);
        check("midrst_perr", {31'd0, parity_err}, 32'd0);
        cyc(10);
        auto_rd = 1'b1;
        key(8'h29, 1'b1, 0);
        drain();
        status("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter FIFO_AW, default 2, meaning FIFO depth = 2^FIFO_AW entries.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 200000, meaning clk cycles without a ps2_clk falling edge before a partial frame is abandoned (2 ms at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz board clock.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port rd  input  1  one-cycle pop strobe from the bus decoder.
REQ-008 SHALL have port data_out  output  10  FIFO head {ext, brk, code[7:0]}; 0 when empty.
REQ-009 SHALL have port ready  output  1  FIFO not empty.
REQ-010 SHALL have port overflow  output  1  sticky; a decoded key was dropped because the FIFO was full.
REQ-011 SHALL have port parity_err  output  1  sticky; a frame failed the odd-parity check.

Function
REQ-012 SHALL synchronize ps2_clk and ps2_data through two flops each, then detect a falling edge as previous-synced=1 and current-synced=0.
REQ-013 SHALL implement receiver states IDLE, SHIFT, CHECK.
REQ-014 SHALL leave IDLE for SHIFT only on a falling edge with synced data=0 (start bit); on data=1, SHALL stay in IDLE.
REQ-015 SHALL in SHIFT sample 8 data bits LSB first, then parity, then stop, one bit per falling edge, using a 4-bit bit counter.
REQ-016 SHALL enter CHECK for exactly one cycle after the stop bit; the frame is valid iff stop=1 and the parity condition in REQ-029/030 holds; an invalid frame is discarded.
REQ-017 SHALL count clk cycles in SHIFT since the last falling edge; at TIMEOUT_CYC SHALL return to IDLE, discard the partial frame, and clear the prefix flags.
REQ-018 SHALL handle a valid byte 0xE0 by setting the ext flag, with no push.
REQ-019 SHALL handle a valid byte 0xF0 by setting the brk flag, with no push.
REQ-020 SHALL push any other valid byte as {ext, brk, byte} and clear both flags in the same cycle; the sequence E0,F0,code SHALL yield ext=1, brk=1.
REQ-021 SHALL make the pushed entry visible (ready=1, data_out valid) no later than 5 clk cycles after the raw ps2_clk falling edge of the stop bit.
REQ-022 SHALL implement the FIFO as registered storage with FIFO_AW-bit read/write pointers that wrap modulo 2^FIFO_AW and an (FIFO_AW+1)-bit count.
REQ-023 SHALL drive data_out combinationally from storage[rd_ptr] when count≠0, else 0, and SHALL drive ready = (count≠0).
REQ-024 SHALL advance rd_ptr on rd while non-empty; rd while empty SHALL be ignored.
REQ-025 SHALL, on a push while full with no rd, drop the entry and set overflow; overflow SHALL clear only on rst.
REQ-026 SHALL, on a simultaneous rd and push while full, perform both, leaving count unchanged with no overflow.
REQ-027 SHALL, on a simultaneous rd and push while empty, ignore rd and store the push, so count=1.

Reset
REQ-028 SHALL on rst=1 at a clk edge set the state to IDLE, the bit counter and timeout counter to 0, ext=brk=0, both pointers and count to 0, and data_out, ready, overflow and parity_err to 0; a frame in progress SHALL be discarded, and reception SHALL resume at the next start bit after rst deasserts.

Configuration
REQ-029 With macro PS2_PARITY_CHK_EN defined, a frame SHALL be valid only if the 8 data bits plus the parity bit contain an odd number of ones; a failing frame SHALL be discarded and SHALL set sticky parity_err.
REQ-030 Without PS2_PARITY_CHK_EN, the parity bit SHALL be ignored, parity_err SHALL be tied to 0, and the validity check SHALL use only stop=1.

Verification
REQ-031 SHALL cover: frame 0x1C with correct parity, stop=1 -> ready=1 within 5 cycles, data_out=0x01C; rd pulse -> ready=0, data_out=0.
REQ-032 SHALL cover: bytes F0,1C -> single entry 0x11C; bytes E0,F0,75 -> single entry 0x375.
REQ-033 SHALL cover: with FIFO_AW=2, 5 keys and no rd -> 4 entries retained in order and overflow=1; with a full FIFO, a push in the same cycle as rd -> count stays 4 and the new key is at the tail.
REQ-034 SHALL cover: frame 0x1C with wrong parity -> with PS2_PARITY_CHK_EN, no push and parity_err=1; without it, entry 0x01C is pushed.
REQ-035 SHALL cover: 4 bits of a frame then silence for TIMEOUT_CYC cycles -> state IDLE; the next full frame 0x29 -> entry 0x029.
REQ-036 SHALL cover: rst pulsed mid-frame after E0 was received -> all outputs 0; the following frame 0x29 -> entry 0x029 (ext cleared).
